bsg_manycore_link_isolate_buffer: RTL and testbench
===================================================

Name: bsg_manycore_link_isolate_buffer

Overview:
- Single-clock, num_links_p-channel buffer placed between processor-side endpoints and the manycore IO router column.
- Each channel has a forward request FIFO and a reverse response buffer.
- Outstanding-request accounting per channel stalls the forward path at max_out_p.
- Per-channel isolation FSM drains traffic, then fences the channel so one endpoint can be reset or parked without corrupting the mesh.

Parameters:
- num_links_p, 3, number of independent channels
- fwd_width_p, 64, forward packet width in bits
- rev_width_p, 40, reverse packet width in bits
- fwd_els_p, 4, forward FIFO depth; power of two, at least 2
- max_out_p, 16, maximum outstanding forward requests per channel; at least 1

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- isolate_i  in  num_links_p  per-channel isolation request, level-sensitive
- proc_fwd_v_i / proc_fwd_data_i / proc_fwd_ready_o  in/in/out  num_links_p / num_links_p*fwd_width_p / num_links_p  requests from endpoint
- net_fwd_v_o / net_fwd_data_o / net_fwd_ready_i  out/out/in  same widths  requests to router
- net_rev_v_i / net_rev_data_i / net_rev_ready_o  in/in/out  num_links_p / num_links_p*rev_width_p / num_links_p  responses from router
- proc_rev_v_o / proc_rev_data_o / proc_rev_ready_i  out/out/in  same widths  responses to endpoint
- isolated_o  out  num_links_p  channel is fully drained and fenced
- out_count_o  out  num_links_p*$clog2(max_out_p+1)  outstanding count per channel
- error_o  out  num_links_p  sticky: response arrived while the outstanding count was 0

Behaviour:
- All handshakes are valid/ready. A transfer occurs when v & ready are both high on a rising edge. Valid never depends combinationally on ready.
- Reset (asynchronous assert, synchronous-edge deassert):
  - FIFOs empty; all counters 0; FSM = RUN.
  - Outputs: net_fwd_v_o=0, proc_rev_v_o=0, isolated_o=0, error_o=0, out_count_o=0.
  - Ready outputs are 0 while reset_i is high.
- Forward path:
  - proc_fwd_ready_o[i] = state==RUN & fifo not full & count<max_out_p.
  - Accepted packet appears on net_fwd_v_o the next cycle (1-cycle latency), in FIFO order.
  - The FIFO keeps draining toward the network in every state.
- Reverse path:
  - Two-element buffer; net_rev_ready_o high whenever the buffer is not full, in every state.
  - Latency is 1 cycle.
  - In ISOLATED, accepted responses are dropped and never forwarded to proc.
- Counter:
  - +1 on proc_fwd handshake; -1 on net_rev handshake.
  - Both in the same cycle: no change.
  - A decrement when the count is 0 saturates at 0 and sets error_o[i] (sticky until reset). That packet is still forwarded unless the channel is ISOLATED.
  - The count never exceeds max_out_p.
- FSM per channel:
  - RUN -> DRAIN when isolate_i[i]=1. A proc_fwd handshake cannot occur in the cycle DRAIN is entered; ready is registered from the state.
  - DRAIN -> ISOLATED when the fwd FIFO is empty, the rev buffer is empty, and count==0.
  - DRAIN -> RUN if isolate_i[i] drops before the drain completes.
  - ISOLATED -> RUN when isolate_i[i]=0.
  - isolated_o[i] = state==ISOLATED, registered.
- Boundary cases:
  - FIFO full with net_fwd_ready_i=0: proc ready stays low and no data is lost.
  - count==max_out_p: proc ready is low even when the FIFO has space.
  - isolate_i asserted while in ISOLATED: state is held.
  - isolate_i asserted and deasserted in the same cycle as drain completes: DRAIN->RUN wins.
- Channels are fully independent; no cross-channel arbitration.

Decomposition:
- bsg_manycore_link_isolate_pkg: state enum (e_iso_run, e_iso_drain, e_iso_isolated) and a count-width helper constant.
- Sub-module bsg_manycore_link_isolate_channel: one channel, containing:
  - bsg_fifo_1r1w_small (fwd)
  - bsg_two_fifo (rev)
  - counter
  - FSM
- The top level is a generate loop over num_links_p.

Test Plan:
- Reset with all ready high; send 4 fwd packets on ch0 -> packets appear on net_fwd in order, each 1 cycle after acceptance; out_count_o[0]=4; return 4 rev -> count 0; error_o=0.
- Hold net_fwd_ready_i[1]=0; push fwd_els_p=4 packets -> proc_fwd_ready_o[1]=0 after the 4th; release ready -> all 4 drained, no loss.
- max_out_p=16 with no responses -> 16 accepted, then ready low even though the FIFO is empty; 1 response -> ready high next cycle.
- Same-cycle fwd accept and rev return at count 5 -> count remains 5.
- Isolation sequence:
  - Raise isolate_i[2] with 3 outstanding -> ready drops immediately; isolated_o[2]=0 until 3 responses return.
  - isolated_o[2]=1 one cycle after the last response.
  - A stray rev packet is then dropped and error_o[2]=1.
  - Lowering isolate_i[2] -> RUN on the next edge.
- Assert reset_i mid-traffic on all channels -> outputs clear asynchronously; after deassertion counts are 0, the FSM is in RUN, and no stale packets are emitted.

Source files
------------

// File: rtl/bsg_manycore_link_isolate_pkg.sv
// ---------------------------------------------------------------------------
// bsg_manycore_link_isolate_pkg
// Purpose: shared types for the manycore link isolation buffer.
//   - iso_state_e : per-channel isolation state (run / drain / isolated)
//   - count_width : width of an outstanding-request counter able to hold
//                   the values 0..max_out inclusive
// Ports: none (package).
// ---------------------------------------------------------------------------
package bsg_manycore_link_isolate_pkg;

  typedef enum logic [1:0] {
    e_iso_run      = 2'd0,
    e_iso_drain    = 2'd1,
    e_iso_isolated = 2'd2
  } iso_state_e;

  // Counter must represent max_out itself, hence the +1.
  function automatic int count_width(input int max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/bsg_manycore_link_isolate_buffer_channel.sv
// ---------------------------------------------------------------------------
// bsg_manycore_link_isolate_buffer_channel
// Purpose: one independent link channel. Holds a small forward request FIFO
//   (proc -> net), a two-entry reverse response buffer (net -> proc), an
//   outstanding-request counter and the isolation FSM.
// Ports:
//   clk_i, reset_i            clock, asynchronous active-high reset
//   isolate_i                 level isolation request
//   proc_fwd_*                requests from the endpoint (v/data/ready)
//   net_fwd_*                 requests toward the router (v/data/ready)
//   net_rev_*                 responses from the router (v/data/ready)
//   proc_rev_*                responses toward the endpoint (v/data/ready)
//   isolated_o                channel drained and fenced
//   out_count_o               outstanding forward requests
//   error_o                   sticky: response seen with zero outstanding
// ---------------------------------------------------------------------------
module bsg_manycore_link_isolate_buffer_channel
  import bsg_manycore_link_isolate_pkg::*;
#(
  parameter int fwd_width_p = 64,
  parameter int rev_width_p = 40,
  parameter int fwd_els_p   = 4,
  parameter int max_out_p   = 16,
  parameter int cnt_width_p = count_width(max_out_p)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   isolate_i,

  input  logic                   proc_fwd_v_i,
  input  logic [fwd_width_p-1:0] proc_fwd_data_i,
  output logic                   proc_fwd_ready_o,

  output logic                   net_fwd_v_o,
  output logic [fwd_width_p-1:0] net_fwd_data_o,
  input  logic                   net_fwd_ready_i,

  input  logic                   net_rev_v_i,
  input  logic [rev_width_p-1:0] net_rev_data_i,
  output logic                   net_rev_ready_o,

  output logic                   proc_rev_v_o,
  output logic [rev_width_p-1:0] proc_rev_data_o,
  input  logic                   proc_rev_ready_i,

  output logic                   isolated_o,
  output logic [cnt_width_p-1:0] out_count_o,
  output logic                   error_o
);

  localparam int ptr_w_lp = $clog2(fwd_els_p);

  localparam logic [ptr_w_lp-1:0]    fwd_ptr_one_lp  = ptr_w_lp'(1);
  localparam logic [ptr_w_lp:0]      fwd_used_one_lp = (ptr_w_lp + 1)'(1);
  localparam logic [ptr_w_lp:0]      fwd_used_max_lp = (ptr_w_lp + 1)'(fwd_els_p);
  localparam logic [cnt_width_p-1:0] cnt_one_lp      = cnt_width_p'(1);
  localparam logic [cnt_width_p-1:0] cnt_max_lp      = cnt_width_p'(max_out_p);

  // ---------------- forward FIFO (bsg_fifo_1r1w_small equivalent) ----------
  logic [fwd_width_p-1:0] r_fwd_mem [fwd_els_p];
  logic [ptr_w_lp-1:0]    r_fwd_wptr;
  logic [ptr_w_lp-1:0]    r_fwd_rptr;
  logic [ptr_w_lp:0]      r_fwd_used;
  logic [ptr_w_lp:0]      w_fwd_used_nxt;
  logic                   w_fwd_full;
  logic                   w_fwd_empty;
  logic                   w_fwd_enq;
  logic                   w_fwd_deq;

  // ---------------- reverse buffer (bsg_two_fifo equivalent) ---------------
  logic [rev_width_p-1:0] r_rev_mem [2];
  logic                   r_rev_wptr;
  logic                   r_rev_rptr;
  logic [1:0]             r_rev_used;
  logic [1:0]             w_rev_used_nxt;
  logic                   w_rev_full;
  logic                   w_rev_empty;
  logic                   w_rev_accept;
  logic                   w_rev_store;
  logic                   w_rev_deq;

  // ---------------- counter / FSM -----------------------------------------
  logic [cnt_width_p-1:0] r_out_cnt;
  logic [cnt_width_p-1:0] w_cnt_nxt;
  logic                   r_error;
  logic                   w_err_nxt;
  logic                   w_cnt_zero;
  logic                   w_at_max;
  logic                   w_proc_fwd_ready;
  logic                   w_drained;
  iso_state_e             r_state;
  iso_state_e             w_state_nxt;

  assign w_fwd_full  = (r_fwd_used == fwd_used_max_lp);
  assign w_fwd_empty = (r_fwd_used == {(ptr_w_lp + 1){1'b0}});
  assign w_rev_full  = (r_rev_used == 2'd2);
  assign w_rev_empty = (r_rev_used == 2'd0);
  assign w_cnt_zero  = (r_out_cnt == {cnt_width_p{1'b0}});
  assign w_at_max    = (r_out_cnt == cnt_max_lp);

  // Ready depends only on registered state, so it never rises with isolate_i
  // in the same cycle; reset forces it low.
  assign w_proc_fwd_ready = ~reset_i & (r_state == e_iso_run) & ~w_fwd_full & ~w_at_max;

  assign w_fwd_enq    = proc_fwd_v_i & w_proc_fwd_ready;
  assign w_fwd_deq    = net_fwd_ready_i & ~w_fwd_empty;
  assign w_rev_accept = net_rev_v_i & net_rev_ready_o;
  // Responses accepted while fenced are consumed but not stored.
  assign w_rev_store  = w_rev_accept & (r_state != e_iso_isolated);
  assign w_rev_deq    = proc_rev_ready_i & ~w_rev_empty;

  // Forward FIFO occupancy next value
  always_comb begin
    w_fwd_used_nxt = r_fwd_used;
    case ({w_fwd_enq, w_fwd_deq})
      2'b10:   w_fwd_used_nxt = r_fwd_used + fwd_used_one_lp;
      2'b01:   w_fwd_used_nxt = r_fwd_used - fwd_used_one_lp;
      default: w_fwd_used_nxt = r_fwd_used;
    endcase
  end

  // Forward FIFO pointers and occupancy
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_fwd_wptr <= {ptr_w_lp{1'b0}};
      r_fwd_rptr <= {ptr_w_lp{1'b0}};
      r_fwd_used <= {(ptr_w_lp + 1){1'b0}};
    end else begin
      if (w_fwd_enq) r_fwd_wptr <= r_fwd_wptr + fwd_ptr_one_lp;
      if (w_fwd_deq) r_fwd_rptr <= r_fwd_rptr + fwd_ptr_one_lp;
      r_fwd_used <= w_fwd_used_nxt;
    end
  end

  // Forward FIFO storage; contents are qualified by occupancy
  always_ff @(posedge clk_i) begin
    if (w_fwd_enq) r_fwd_mem[r_fwd_wptr] <= proc_fwd_data_i;
  end

  // Reverse buffer occupancy next value
  always_comb begin
    w_rev_used_nxt = r_rev_used;
    case ({w_rev_store, w_rev_deq})
      2'b10:   w_rev_used_nxt = r_rev_used + 2'd1;
      2'b01:   w_rev_used_nxt = r_rev_used - 2'd1;
      default: w_rev_used_nxt = r_rev_used;
    endcase
  end

  // Reverse buffer pointers and occupancy
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_rev_wptr <= 1'b0;
      r_rev_rptr <= 1'b0;
      r_rev_used <= 2'd0;
    end else begin
      if (w_rev_store) r_rev_wptr <= ~r_rev_wptr;
      if (w_rev_deq)   r_rev_rptr <= ~r_rev_rptr;
      r_rev_used <= w_rev_used_nxt;
    end
  end

  // Reverse buffer storage; contents are qualified by occupancy
  always_ff @(posedge clk_i) begin
    if (w_rev_store) r_rev_mem[r_rev_wptr] <= net_rev_data_i;
  end

  // Outstanding counter and sticky error next values
  always_comb begin
    w_cnt_nxt = r_out_cnt;
    w_err_nxt = r_error;
    case ({w_fwd_enq, w_rev_accept})
      // Increment only happens when ready, i.e. below max_out_p.
      2'b10: w_cnt_nxt = r_out_cnt + cnt_one_lp;
      2'b01: begin
        if (w_cnt_zero) w_cnt_nxt = r_out_cnt;
        else            w_cnt_nxt = r_out_cnt - cnt_one_lp;
      end
      default: w_cnt_nxt = r_out_cnt;
    endcase
    if (w_rev_accept & w_cnt_zero) w_err_nxt = 1'b1;
    else                           w_err_nxt = r_error;
  end

  // Outstanding counter and sticky error registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_out_cnt <= {cnt_width_p{1'b0}};
      r_error   <= 1'b0;
    end else begin
      r_out_cnt <= w_cnt_nxt;
      r_error   <= w_err_nxt;
    end
  end

  // Drain is judged on post-edge occupancy so the fence closes on the same
  // edge the last response leaves the reverse buffer.
  assign w_drained = (w_fwd_used_nxt == {(ptr_w_lp + 1){1'b0}})
                   & (w_rev_used_nxt == 2'd0)
                   & (w_cnt_nxt == {cnt_width_p{1'b0}});

  // Isolation FSM next state; a dropped request always wins over completion
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      e_iso_run: begin
        if (isolate_i) w_state_nxt = e_iso_drain;
        else           w_state_nxt = e_iso_run;
      end
      e_iso_drain: begin
        if (~isolate_i)     w_state_nxt = e_iso_run;
        else if (w_drained) w_state_nxt = e_iso_isolated;
        else                w_state_nxt = e_iso_drain;
      end
      e_iso_isolated: begin
        if (~isolate_i) w_state_nxt = e_iso_run;
        else            w_state_nxt = e_iso_isolated;
      end
      default: w_state_nxt = e_iso_run;
    endcase
  end

  // Isolation FSM state register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_state <= e_iso_run;
    else         r_state <= w_state_nxt;
  end

  assign proc_fwd_ready_o = w_proc_fwd_ready;
  assign net_fwd_v_o      = ~w_fwd_empty;
  assign net_fwd_data_o   = r_fwd_mem[r_fwd_rptr];
  assign net_rev_ready_o  = ~reset_i & ~w_rev_full;
  assign proc_rev_v_o     = ~w_rev_empty;
  assign proc_rev_data_o  = r_rev_mem[r_rev_rptr];
  assign isolated_o       = (r_state == e_iso_isolated);
  assign out_count_o      = r_out_cnt;
  assign error_o          = r_error;

endmodule

// File: rtl/bsg_manycore_link_isolate_buffer.sv
// ---------------------------------------------------------------------------
// bsg_manycore_link_isolate_buffer
// Purpose: num_links_p independent link channels between processor-side
//   endpoints and the manycore IO router column. Each channel buffers
//   forward requests and reverse responses, tracks outstanding requests,
//   and can be drained and fenced on request.
// Ports (all vectors are channel-major, channel i in the i-th slice):
//   clk_i, reset_i           clock, asynchronous active-high reset
//   isolate_i                per-channel isolation request
//   proc_fwd_* / net_fwd_*   forward request path (v/data/ready)
//   net_rev_* / proc_rev_*   reverse response path (v/data/ready)
//   isolated_o               per-channel fenced status
//   out_count_o              per-channel outstanding count
//   error_o                  per-channel sticky unexpected-response flag
// ---------------------------------------------------------------------------
module bsg_manycore_link_isolate_buffer
  import bsg_manycore_link_isolate_pkg::*;
#(
  parameter int num_links_p = 3,
  parameter int fwd_width_p = 64,
  parameter int rev_width_p = 40,
  parameter int fwd_els_p   = 4,
  parameter int max_out_p   = 16
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic [num_links_p-1:0]              isolate_i,

  input  logic [num_links_p-1:0]              proc_fwd_v_i,
  input  logic [num_links_p*fwd_width_p-1:0]  proc_fwd_data_i,
  output logic [num_links_p-1:0]              proc_fwd_ready_o,

  output logic [num_links_p-1:0]              net_fwd_v_o,
  output logic [num_links_p*fwd_width_p-1:0]  net_fwd_data_o,
  input  logic [num_links_p-1:0]              net_fwd_ready_i,

  input  logic [num_links_p-1:0]              net_rev_v_i,
  input  logic [num_links_p*rev_width_p-1:0]  net_rev_data_i,
  output logic [num_links_p-1:0]              net_rev_ready_o,

  output logic [num_links_p-1:0]              proc_rev_v_o,
  output logic [num_links_p*rev_width_p-1:0]  proc_rev_data_o,
  input  logic [num_links_p-1:0]              proc_rev_ready_i,

  output logic [num_links_p-1:0]              isolated_o,
  output logic [num_links_p*count_width(max_out_p)-1:0] out_count_o,
  output logic [num_links_p-1:0]              error_o
);

  localparam int cnt_width_lp = count_width(max_out_p);

  for (genvar g = 0; g < num_links_p; g++) begin : g_link
    bsg_manycore_link_isolate_buffer_channel #(
      .fwd_width_p (fwd_width_p),
      .rev_width_p (rev_width_p),
      .fwd_els_p   (fwd_els_p),
      .max_out_p   (max_out_p),
      .cnt_width_p (cnt_width_lp)
    ) u_chan (
      .clk_i            (clk_i),
      .reset_i          (reset_i),
      .isolate_i        (isolate_i[g]),
      .proc_fwd_v_i     (proc_fwd_v_i[g]),
      .proc_fwd_data_i  (proc_fwd_data_i[g*fwd_width_p +: fwd_width_p]),
      .proc_fwd_ready_o (proc_fwd_ready_o[g]),
      .net_fwd_v_o      (net_fwd_v_o[g]),
      .net_fwd_data_o   (net_fwd_data_o[g*fwd_width_p +: fwd_width_p]),
      .net_fwd_ready_i  (net_fwd_ready_i[g]),
      .net_rev_v_i      (net_rev_v_i[g]),
      .net_rev_data_i   (net_rev_data_i[g*rev_width_p +: rev_width_p]),
      .net_rev_ready_o  (net_rev_ready_o[g]),
      .proc_rev_v_o     (proc_rev_v_o[g]),
      .proc_rev_data_o  (proc_rev_data_o[g*rev_width_p +: rev_width_p]),
      .proc_rev_ready_i (proc_rev_ready_i[g]),
      .isolated_o       (isolated_o[g]),
      .out_count_o      (out_count_o[g*cnt_width_lp +: cnt_width_lp]),
      .error_o          (error_o[g])
    );
  end

endmodule

// File: tb/tb_bsg_manycore_link_isolate_buffer.sv
// ---------------------------------------------------------------------------
// tb_bsg_manycore_link_isolate_buffer
// Purpose: directed self-checking bench for the link isolation buffer.
// ---------------------------------------------------------------------------
module tb_bsg_manycore_link_isolate_buffer;

  localparam int NL = 3;
  localparam int FW = 64;
  localparam int RW = 40;
  localparam int FE = 4;
  localparam int MO = 16;
  localparam int CW = $clog2(MO + 1);

  logic               clk_i;
  logic               reset_i;
  logic [NL-1:0]      isolate_i;
  logic [NL-1:0]      proc_fwd_v_i;
  logic [NL*FW-1:0]   proc_fwd_data_i;
  logic [NL-1:0]      proc_fwd_ready_o;
  logic [NL-1:0]      net_fwd_v_o;
  logic [NL*FW-1:0]   net_fwd_data_o;
  logic [NL-1:0]      net_fwd_ready_i;
  logic [NL-1:0]      net_rev_v_i;
  logic [NL*RW-1:0]   net_rev_data_i;
  logic [NL-1:0]      net_rev_ready_o;
  logic [NL-1:0]      proc_rev_v_o;
  logic [NL*RW-1:0]   proc_rev_data_o;
  logic [NL-1:0]      proc_rev_ready_i;
  logic [NL-1:0]      isolated_o;
  logic [NL*CW-1:0]   out_count_o;
  logic [NL-1:0]      error_o;

  int n_checks;
  int n_fail;

  bsg_manycore_link_isolate_buffer #(
    .num_links_p (NL),
    .fwd_width_p (FW),
    .rev_width_p (RW),
    .fwd_els_p   (FE),
    .max_out_p   (MO)
  ) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .isolate_i        (isolate_i),
    .proc_fwd_v_i     (proc_fwd_v_i),
    .proc_fwd_data_i  (proc_fwd_data_i),
    .proc_fwd_ready_o (proc_fwd_ready_o),
    .net_fwd_v_o      (net_fwd_v_o),
    .net_fwd_data_o   (net_fwd_data_o),
    .net_fwd_ready_i  (net_fwd_ready_i),
    .net_rev_v_i      (net_rev_v_i),
    .net_rev_data_i   (net_rev_data_i),
    .net_rev_ready_o  (net_rev_ready_o),
    .proc_rev_v_o     (proc_rev_v_o),
    .proc_rev_data_o  (proc_rev_data_o),
    .proc_rev_ready_i (proc_rev_ready_i),
    .isolated_o       (isolated_o),
    .out_count_o      (out_count_o),
    .error_o          (error_o)
  );

  // Free-running clock
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [63:0] fwd_dat(input int ch);
    return net_fwd_data_o[ch*FW +: FW];
  endfunction

  function automatic logic [63:0] rev_dat(input int ch);
    return 64'(proc_rev_data_o[ch*RW +: RW]);
  endfunction

  function automatic logic [63:0] cnt(input int ch);
    return 64'(out_count_o[ch*CW +: CW]);
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_i          = 1'b1;
    isolate_i        = 3'b000;
    proc_fwd_v_i     = 3'b000;
    proc_fwd_data_i  = '0;
    net_fwd_ready_i  = 3'b111;
    net_rev_v_i      = 3'b000;
    net_rev_data_i   = '0;
    proc_rev_ready_i = 3'b111;

    // ---- reset state ----
    #1;
    check_val("rst_proc_fwd_ready", 64'(proc_fwd_ready_o), 64'h0);
    check_val("rst_net_rev_ready",  64'(net_rev_ready_o),  64'h0);
    check_val("rst_net_fwd_v",      64'(net_fwd_v_o),      64'h0);
    check_val("rst_proc_rev_v",     64'(proc_rev_v_o),     64'h0);
    check_val("rst_isolated",       64'(isolated_o),       64'h0);
    check_val("rst_error",          64'(error_o),          64'h0);
    check_val("rst_count",          64'(out_count_o),      64'h0);
    tick();
    tick();
    reset_i = 1'b0;
    #1;
    check_val("post_rst_proc_ready", 64'(proc_fwd_ready_o), 64'h7);
    check_val("post_rst_rev_ready",  64'(net_rev_ready_o),  64'h7);

    // ---- ch0: 4 forward packets, each visible one cycle after acceptance ----
    for (int k = 0; k < 4; k++) begin
      proc_fwd_v_i[0] = 1'b1;
      proc_fwd_data_i[0 +: FW] = 64'hA000_0000_0000_0000 + 64'(k);
      tick();
      check_val("c0_fwd_v",    64'(net_fwd_v_o[0]), 64'h1);
      check_val("c0_fwd_data", fwd_dat(0), 64'hA000_0000_0000_0000 + 64'(k));
    end
    proc_fwd_v_i[0] = 1'b0;
    tick();
    check_val("c0_fwd_drained", 64'(net_fwd_v_o[0]), 64'h0);
    check_val("c0_count4",      cnt(0), 64'd4);

    // ---- ch0: 4 responses return, count back to 0 ----
    for (int k = 0; k < 4; k++) begin
      net_rev_v_i[0] = 1'b1;
      net_rev_data_i[0 +: RW] = 40'hB0_0000_0000 + 40'(k);
      tick();
      check_val("c0_rev_v",    64'(proc_rev_v_o[0]), 64'h1);
      check_val("c0_rev_data", rev_dat(0), 64'h00B0_0000_0000 + 64'(k));
    end
    net_rev_v_i[0] = 1'b0;
    check_val("c0_count0", cnt(0), 64'd0);
    check_val("c0_error0", 64'(error_o[0]), 64'h0);
    tick();
    check_val("c0_rev_empty", 64'(proc_rev_v_o[0]), 64'h0);

    // ---- ch1: FIFO fills with net ready low, then drains in order ----
    net_fwd_ready_i[1] = 1'b0;
    for (int k = 0; k < FE; k++) begin
      check_val("c1_ready_before_full", 64'(proc_fwd_ready_o[1]), 64'h1);
      proc_fwd_v_i[1] = 1'b1;
      proc_fwd_data_i[FW +: FW] = 64'hC100_0000_0000_0000 + 64'(k);
      tick();
    end
    proc_fwd_v_i[1] = 1'b0;
    check_val("c1_ready_full", 64'(proc_fwd_ready_o[1]), 64'h0);
    tick();
    check_val("c1_ready_still_full", 64'(proc_fwd_ready_o[1]), 64'h0);
    net_fwd_ready_i[1] = 1'b1;
    for (int k = 0; k < FE; k++) begin
      check_val("c1_drain_v",    64'(net_fwd_v_o[1]), 64'h1);
      check_val("c1_drain_data", fwd_dat(1), 64'hC100_0000_0000_0000 + 64'(k));
      tick();
    end
    check_val("c1_drain_done", 64'(net_fwd_v_o[1]), 64'h0);

    // ---- ch0: outstanding limit with an empty FIFO ----
    for (int k = 0; k < MO; k++) begin
      proc_fwd_v_i[0] = 1'b1;
      proc_fwd_data_i[0 +: FW] = 64'hD000_0000_0000_0000 + 64'(k);
      tick();
    end
    proc_fwd_v_i[0] = 1'b0;
    check_val("c0_count_max", cnt(0), 64'd16);
    check_val("c0_ready_at_max", 64'(proc_fwd_ready_o[0]), 64'h0);
    tick();
    check_val("c0_fifo_empty_at_max", 64'(net_fwd_v_o[0]), 64'h0);
    check_val("c0_ready_max_empty",   64'(proc_fwd_ready_o[0]), 64'h0);
    net_rev_v_i[0] = 1'b1;
    tick();
    net_rev_v_i[0] = 1'b0;
    check_val("c0_count15", cnt(0), 64'd15);
    check_val("c0_ready_after_rsp", 64'(proc_fwd_ready_o[0]), 64'h1);

    // ---- ch0: bring count to 5, then simultaneous accept and return ----
    net_rev_v_i[0] = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    net_rev_v_i[0] = 1'b0;
    check_val("c0_count5", cnt(0), 64'd5);
    proc_fwd_v_i[0] = 1'b1;
    net_rev_v_i[0]  = 1'b1;
    tick();
    proc_fwd_v_i[0] = 1'b0;
    net_rev_v_i[0]  = 1'b0;
    check_val("c0_same_cycle", cnt(0), 64'd5);
    check_val("c0_error_still0", 64'(error_o[0]), 64'h0);

    // ---- ch2: isolation sequence ----
    for (int k = 0; k < 3; k++) begin
      proc_fwd_v_i[2] = 1'b1;
      proc_fwd_data_i[2*FW +: FW] = 64'hE200_0000_0000_0000 + 64'(k);
      tick();
    end
    proc_fwd_v_i[2] = 1'b0;
    check_val("c2_count3", cnt(2), 64'd3);
    isolate_i[2] = 1'b1;
    tick();
    check_val("c2_ready_drain", 64'(proc_fwd_ready_o[2]), 64'h0);
    check_val("c2_not_iso_0",   64'(isolated_o[2]), 64'h0);
    for (int k = 0; k < 3; k++) begin
      net_rev_v_i[2] = 1'b1;
      net_rev_data_i[2*RW +: RW] = 40'hF2_0000_0000 + 40'(k);
      tick();
      check_val("c2_not_iso_rsp", 64'(isolated_o[2]), 64'h0);
    end
    net_rev_v_i[2] = 1'b0;
    check_val("c2_count0", cnt(2), 64'd0);
    tick();
    check_val("c2_isolated", 64'(isolated_o[2]), 64'h1);
    check_val("c2_stray_ready", 64'(net_rev_ready_o[2]), 64'h1);
    net_rev_v_i[2] = 1'b1;
    net_rev_data_i[2*RW +: RW] = 40'hEE_EEEE_EEEE;
    tick();
    net_rev_v_i[2] = 1'b0;
    check_val("c2_stray_dropped", 64'(proc_rev_v_o[2]), 64'h0);
    check_val("c2_error",         64'(error_o[2]), 64'h1);
    tick();
    check_val("c2_iso_held", 64'(isolated_o[2]), 64'h1);
    check_val("c2_stray_dropped2", 64'(proc_rev_v_o[2]), 64'h0);
    isolate_i[2] = 1'b0;
    tick();
    check_val("c2_back_run",   64'(isolated_o[2]), 64'h0);
    check_val("c2_ready_run",  64'(proc_fwd_ready_o[2]), 64'h1);
    check_val("c2_error_sticky", 64'(error_o[2]), 64'h1);

    // ---- mid-traffic asynchronous reset ----
    net_fwd_ready_i  = 3'b000;
    proc_rev_ready_i = 3'b000;
    proc_fwd_v_i     = 3'b111;
    net_rev_v_i      = 3'b111;
    tick();
    tick();
    check_val("pre_rst_fwd_v", 64'(net_fwd_v_o),  64'h7);
    check_val("pre_rst_rev_v", 64'(proc_rev_v_o), 64'h7);
    #2;
    reset_i = 1'b1;
    #1;
    check_val("arst_net_fwd_v",  64'(net_fwd_v_o),      64'h0);
    check_val("arst_proc_rev_v", 64'(proc_rev_v_o),     64'h0);
    check_val("arst_count",      64'(out_count_o),      64'h0);
    check_val("arst_error",      64'(error_o),          64'h0);
    check_val("arst_ready",      64'(proc_fwd_ready_o), 64'h0);
    proc_fwd_v_i     = 3'b000;
    net_rev_v_i      = 3'b000;
    net_fwd_ready_i  = 3'b111;
    proc_rev_ready_i = 3'b111;
    tick();
    reset_i = 1'b0;
    #1;
    check_val("post_arst_ready", 64'(proc_fwd_ready_o), 64'h7);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_val("post_arst_no_fwd", 64'(net_fwd_v_o),  64'h0);
      check_val("post_arst_no_rev", 64'(proc_rev_v_o), 64'h0);
    end
    check_val("post_arst_count",    64'(out_count_o), 64'h0);
    check_val("post_arst_isolated", 64'(isolated_o),  64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
